// File: rtl/count4bit_down_if.sv
// Control/status bundle for count4bit_down.
//  jk_set, jk_j, jk_k, jk_load_val : control from the driving block (master)
//  jk_q, jk_zero, jk_tc, jk_done    : counter status back to the driving block
interface count4bit_down_if #(
  parameter int unsigned WIDTH = 4
);
  logic             jk_set;
  logic             jk_j;
  logic             jk_k;
  logic [WIDTH-1:0] jk_load_val;
  logic [WIDTH-1:0] jk_q;
  logic             jk_zero;
  logic             jk_tc;
  logic             jk_done;

  modport master (
    output jk_set, jk_j, jk_k, jk_load_val,
    input  jk_q, jk_zero, jk_tc, jk_done
  );

  modport slave (
    input  jk_set, jk_j, jk_k, jk_load_val,
    output jk_q, jk_zero, jk_tc, jk_done
  );
endinterface

// File: rtl/count4bit_down.sv
// Down-counter with JK-style control and an optional one-shot halt at zero.
//  jk_clk  : rising-edge clock
//  jk_rs   : asynchronous active-high reset
//  bus     : slave side of count4bit_down_if
//            {jk_j,jk_k} 00 hold, 01 clear, 10 load jk_load_val, 11 decrement;
//            jk_set presets to PRESET_VAL and overrides J/K.
//            jk_q, jk_tc, jk_done registered; jk_zero decoded from jk_q.
module count4bit_down #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = WIDTH'(15),
  parameter bit               ONE_SHOT   = 1'b0
) (
  input  logic           jk_clk,
  input  logic           jk_rs,
  count4bit_down_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic             tc, tc_n;
  logic             done, done_n;

  // State and output registers.
  always_ff @(posedge jk_clk or posedge jk_rs) begin
    if (jk_rs) begin
      state <= RUN;
      q     <= ZERO_VAL;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      tc    <= tc_n;
      done  <= done_n;
    end
  end

  // Next-state: set beats J/K; tc is a one-cycle pulse so it defaults low.
  always_comb begin
    state_n = state;
    q_n     = q;
    tc_n    = 1'b0;
    done_n  = done;

    if (bus.jk_set) begin
      q_n     = PRESET_VAL;
      done_n  = 1'b0;
      state_n = RUN;
    end else begin
      case ({bus.jk_j, bus.jk_k})
        2'b00: begin
        end
        2'b01: begin
          q_n     = ZERO_VAL;
          done_n  = 1'b0;
          state_n = RUN;
        end
        2'b10: begin
          q_n     = bus.jk_load_val;
          done_n  = 1'b0;
          state_n = RUN;
        end
        default: begin
          if (state == HALT) begin
            q_n = ZERO_VAL;
          end else if (q == ONE_VAL) begin
            // Only the 1 -> 0 step counts as terminal.
            q_n  = ZERO_VAL;
            tc_n = 1'b1;
            if (ONE_SHOT) begin
              state_n = HALT;
              done_n  = 1'b1;
            end
          end else if (q == ZERO_VAL) begin
            if (ONE_SHOT) begin
              state_n = HALT;
              done_n  = 1'b1;
            end else begin
              q_n = MAX_VAL;
            end
          end else begin
            q_n = q - ONE_VAL;
          end
        end
      endcase
    end
  end

  assign bus.jk_q    = q;
  assign bus.jk_tc   = tc;
  assign bus.jk_done = done;
  assign bus.jk_zero = (q == ZERO_VAL);

endmodule

// File: tb/tb_count4bit_down.sv
// Scoreboard bench for count4bit_down: a free-running (u0) and a one-shot (u1)
// instance share stimulus; a reference model predicts each edge's result.
module tb_count4bit_down;

  localparam int unsigned WIDTH = 4;
  localparam int          MAXV  = (1 << WIDTH) - 1;
  localparam int          PRESET = 15;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             done;
  } exp_t;

  logic clk;
  logic rs;

  count4bit_down_if #(.WIDTH(WIDTH)) bus0 ();
  count4bit_down_if #(.WIDTH(WIDTH)) bus1 ();

  count4bit_down #(.WIDTH(WIDTH), .PRESET_VAL(4'hF), .ONE_SHOT(1'b0)) u0 (
    .jk_clk(clk), .jk_rs(rs), .bus(bus0)
  );
  count4bit_down #(.WIDTH(WIDTH), .PRESET_VAL(4'hF), .ONE_SHOT(1'b1)) u1 (
    .jk_clk(clk), .jk_rs(rs), .bus(bus1)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  int mq[2];
  bit mtc[2];
  bit mdone[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of one edge; inst 1 is the one-shot counter.
  task automatic model_edge(input int inst, input bit s, input bit j, input bit k, input int lv);
    bit os;
    os = (inst == 1);
    mtc[inst] = 1'b0;
    if (s) begin
      mq[inst] = PRESET; mdone[inst] = 1'b0;
    end else if (!j && k) begin
      mq[inst] = 0; mdone[inst] = 1'b0;
    end else if (j && !k) begin
      mq[inst] = lv; mdone[inst] = 1'b0;
    end else if (j && k) begin
      if (os && mdone[inst]) begin
        mq[inst] = 0;
      end else if (mq[inst] == 0) begin
        if (os) mdone[inst] = 1'b1;
        else    mq[inst] = MAXV;
      end else begin
        mq[inst] = mq[inst] - 1;
        if (mq[inst] == 0) begin
          mtc[inst] = 1'b1;
          if (os) mdone[inst] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mtc[i] = 1'b0; mdone[i] = 1'b0;
    end
  endtask

  // Drive one cycle of control on the falling edge and queue the prediction.
  task automatic step(input bit s, input bit j, input bit k, input int lv);
    exp_t e;
    @(negedge clk);
    bus0.jk_set = s; bus0.jk_j = j; bus0.jk_k = k; bus0.jk_load_val = WIDTH'(lv);
    bus1.jk_set = s; bus1.jk_j = j; bus1.jk_k = k; bus1.jk_load_val = WIDTH'(lv);
    for (int i = 0; i < 2; i++) model_edge(i, s, j, k, lv);
    e.q = WIDTH'(mq[0]); e.tc = mtc[0]; e.done = mdone[0]; sb0.push_back(e);
    e.q = WIDTH'(mq[1]); e.tc = mtc[1]; e.done = mdone[1]; sb1.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q0"},    int'(bus0.jk_q), 0);
    check({tag, "_tc0"},   int'(bus0.jk_tc), 0);
    check({tag, "_done0"}, int'(bus0.jk_done), 0);
    check({tag, "_q1"},    int'(bus1.jk_q), 0);
    check({tag, "_tc1"},   int'(bus1.jk_tc), 0);
    check({tag, "_done1"}, int'(bus1.jk_done), 0);
    check({tag, "_zero1"}, int'(bus1.jk_zero), 1);
  endtask

  task automatic idle_inputs();
    bus0.jk_set = 1'b0; bus0.jk_j = 1'b0; bus0.jk_k = 1'b0; bus0.jk_load_val = '0;
    bus1.jk_set = 1'b0; bus1.jk_j = 1'b0; bus1.jk_k = 1'b0; bus1.jk_load_val = '0;
  endtask

  // Monitor: the DUT presents a result every edge; compare whenever one is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        check("u0_q",    int'(bus0.jk_q),    int'(e.q));
        check("u0_tc",   int'(bus0.jk_tc),   int'(e.tc));
        check("u0_done", int'(bus0.jk_done), int'(e.done));
        check("u0_zero", int'(bus0.jk_zero), int'(e.q == '0));
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check("u1_q",    int'(bus1.jk_q),    int'(e.q));
        check("u1_tc",   int'(bus1.jk_tc),   int'(e.tc));
        check("u1_done", int'(bus1.jk_done), int'(e.done));
        check("u1_zero", int'(bus1.jk_zero), int'(e.q == '0));
      end
    end
  end

  initial begin
    int r;
    int lv;
    rs = 1'b0;
    idle_inputs();
    model_reset();
    #1 rs = 1'b1;
    #2 check_reset_state("por");
    @(negedge clk);
    rs = 1'b0;

    // Free-running wrap and terminal pulse after 1 -> 0.
    step(0, 1, 0, 3);
    repeat (5) step(0, 1, 1, 0);

    // One-shot halt at zero.
    step(0, 1, 0, 2);
    repeat (4) step(0, 1, 1, 0);

    // Load out of HALT, then decrement.
    step(0, 1, 0, 9);
    step(0, 1, 1, 0);

    // Set overrides clear on the same edge.
    step(1, 0, 1, 0);

    // Hold for many edges, then clear.
    step(0, 1, 0, 7);
    repeat (10) step(0, 0, 0, $urandom_range(0, MAXV));
    step(0, 0, 1, 0);

    // Two terminal pulses separated by a load of 1.
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);

    // Asynchronous reset mid-count, observed before the next edge.
    step(0, 1, 0, 5);
    step(0, 1, 1, 0);
    @(posedge clk);
    #2;
    idle_inputs();
    rs = 1'b1;
    #1 check_reset_state("async");
    #1 rs = 1'b0;
    model_reset();

    // Randomized traffic, biased toward decrement so both wrap and halt occur.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 15));
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, MAXV));
      if (r == 0)      step(1, $urandom_range(0, 1), $urandom_range(0, 1), lv);
      else if (r < 2)  step(0, 0, 1, lv);
      else if (r < 5)  step(0, 1, 0, lv);
      else if (r < 7)  step(0, 0, 0, lv);
      else             step(0, 1, 1, lv);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drain0", sb0.size(), 0);
    check("sb_drain1", sb1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
